// File: rtl/apu_pkg.sv
// Shared encodings for the APU frame sequencer: modes, step indices and
// per-mode event masks indexed by the step being left.
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } stepT;

  // Bit n set means "emit the strobe when leaving step n".
  localparam logic [4:0] QUARTER_MASK_4 = 5'b01111;
  localparam logic [4:0] HALF_MASK_4    = 5'b01010;
  localparam stepT       IRQ_STEP_4     = S3;

  localparam logic [4:0] QUARTER_MASK_5 = 5'b10111;
  localparam logic [4:0] HALF_MASK_5    = 5'b10010;

  function automatic stepT nextStep(input stepT cur, input logic mode);
    stepT lastStep;
    lastStep = (mode == MODE_5STEP) ? S4 : S3;
    if (cur >= lastStep) return S0;
    return stepT'(cur + 3'd1);
  endfunction

endpackage

// File: rtl/apu_prescaler.sv
// Clock-enable divider: one registered tick every SAMPLE_DIV enabled clocks.
// Holds its count while en=0; clr restarts the count from zero.
module apu_prescaler #(
  parameter int SAMPLE_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] preCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preCnt <= '0;
      tick   <= 1'b0;
    end else if (clr) begin
      preCnt <= '0;
      tick   <= 1'b0;
    end else if (en) begin
      if (preCnt == PRE_LAST) begin
        preCnt <= '0;
        tick   <= 1'b1;
      end else begin
        preCnt <= preCnt + CW'(1);
        tick   <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 4/5-step frame timing with quarter/half-frame strobes
// and a sticky frame IRQ, configured through a frame-counter style byte write.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int SAMPLE_DIV = 50,
  parameter int STEP_TICKS = 3729
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_en,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       irq_ack,
  output logic       sample_tick,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  localparam logic [11:0] TICK_LAST = 12'(STEP_TICKS - 1);

  stepT        stepReg, stepNext;
  logic        modeReg, modeNext;
  logic        inhibitReg, inhibitNext;
  logic [11:0] tickCnt, tickCntNext;
  logic        quarterNext, halfNext, irqNext;
  logic        irqSet, irqClr;
  logic [4:0]  quarterMask, halfMask;
  logic        unusedCfgBits;

  assign unusedCfgBits = ^cfg_data[5:0];

  apu_prescaler #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) prescaler (
    .clk (clk),
    .rst (rst),
    .en  (apu_en),
    .clr (cfg_we),
    .tick(sample_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepReg       <= S0;
      modeReg       <= MODE_4STEP;
      inhibitReg    <= 1'b0;
      tickCnt       <= '0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      stepReg       <= stepNext;
      modeReg       <= modeNext;
      inhibitReg    <= inhibitNext;
      tickCnt       <= tickCntNext;
      quarter_frame <= quarterNext;
      half_frame    <= halfNext;
      frame_irq     <= irqNext;
    end
  end

  always_comb begin
    quarterMask = (modeReg == MODE_5STEP) ? QUARTER_MASK_5 : QUARTER_MASK_4;
    halfMask    = (modeReg == MODE_5STEP) ? HALF_MASK_5 : HALF_MASK_4;
    stepNext    = stepReg;
    modeNext    = modeReg;
    inhibitNext = inhibitReg;
    tickCntNext = tickCnt;
    quarterNext = 1'b0;
    halfNext    = 1'b0;
    irqSet      = 1'b0;
    irqClr      = irq_ack;

    // A config write pre-empts any step completing in the same cycle.
    if (cfg_we) begin
      modeNext    = cfg_data[7];
      inhibitNext = cfg_data[6];
      tickCntNext = '0;
      stepNext    = S0;
      quarterNext = cfg_data[7];
      halfNext    = cfg_data[7];
      irqClr      = irq_ack | cfg_data[6];
    end else if (apu_en && sample_tick) begin
      if (tickCnt == TICK_LAST) begin
        tickCntNext = '0;
        stepNext    = nextStep(stepReg, modeReg);
        quarterNext = quarterMask[stepReg];
        halfNext    = halfMask[stepReg];
        irqSet      = (modeReg == MODE_4STEP) && (stepReg == IRQ_STEP_4) && !inhibitReg;
      end else begin
        tickCntNext = tickCnt + 12'd1;
      end
    end

    // Set beats clear, so an ack landing on the setting edge is ignored.
    if (irqSet)      irqNext = 1'b1;
    else if (irqClr) irqNext = 1'b0;
    else             irqNext = frame_irq;
  end

  assign step = stepReg;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with SAMPLE_DIV=4, STEP_TICKS=3:
// ticks every 4 clks, step completions every 12 clks, strobes 1 clk after the tick.
`timescale 1ns/1ps
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       apu_en;
  logic       cfg_we;
  logic [7:0] cfg_data;
  logic       irq_ack;
  logic       sample_tick;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;

  int pass_cnt  = 0;
  int total_cnt = 0;

  apu_frame_sequencer #(
    .SAMPLE_DIV(4),
    .STEP_TICKS(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .apu_en       (apu_en),
    .cfg_we       (cfg_we),
    .cfg_data     (cfg_data),
    .irq_ack      (irq_ack),
    .sample_tick  (sample_tick),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .frame_irq    (frame_irq),
    .step         (step)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_data = data;
    cyc();
    cfg_we   = 1'b0;
    cfg_data = 8'h00;
    $display("cfg write 0x%02h at %0t", data, $time);
  endtask

  task automatic test_reset();
    rst = 1'b1; apu_en = 1'b1; cfg_we = 1'b0; cfg_data = 8'h00; irq_ack = 1'b0;
    repeat (3) cyc();
    total_cnt++; if (sample_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", sample_tick); else pass_cnt++;
    total_cnt++; if (quarter_frame !== 1'b0) $display("FAIL reset_quarter got %b want 0", quarter_frame); else pass_cnt++;
    total_cnt++; if (half_frame !== 1'b0) $display("FAIL reset_half got %b want 0", half_frame); else pass_cnt++;
    total_cnt++; if (frame_irq !== 1'b0) $display("FAIL reset_irq got %b want 0", frame_irq); else pass_cnt++;
    total_cnt++; if (step !== 3'd0) $display("FAIL reset_step got %0d want 0", step); else pass_cnt++;
    rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  // Completions at edges 13,25,37,49 leave S0..S3; IRQ sets on leaving S3.
  task automatic test_four_step();
    int k;
    logic expT, expQ, expH, expI;
    logic [2:0] expS;
    expS = 3'd0;
    for (int e = 1; e <= 49; e++) begin
      cyc();
      expT = (e % 4 == 0);
      expQ = 1'b0; expH = 1'b0;
      if (e >= 13 && (e - 13) % 12 == 0) begin
        k = (e - 13) / 12;
        expQ = 1'b1;
        expH = (k % 4 == 1) || (k % 4 == 3);
        expS = 3'((k + 1) % 4);
      end
      expI = (e >= 49);
      total_cnt++; if (sample_tick !== expT) $display("FAIL four_tick e=%0d got %b want %b", e, sample_tick, expT); else pass_cnt++;
      total_cnt++; if (quarter_frame !== expQ) $display("FAIL four_quarter e=%0d got %b want %b", e, quarter_frame, expQ); else pass_cnt++;
      total_cnt++; if (half_frame !== expH) $display("FAIL four_half e=%0d got %b want %b", e, half_frame, expH); else pass_cnt++;
      total_cnt++; if (step !== expS) $display("FAIL four_step e=%0d got %0d want %0d", e, step, expS); else pass_cnt++;
      total_cnt++; if (frame_irq !== expI) $display("FAIL four_irq e=%0d got %b want %b", e, frame_irq, expI); else pass_cnt++;
    end
    $display("four-step frame complete, step=%0d irq=%b", step, frame_irq);
  endtask

  task automatic test_irq_inhibit();
    cfg_write(8'h40);
    total_cnt++; if (frame_irq !== 1'b0) $display("FAIL inhibit_clear got %b want 0", frame_irq); else pass_cnt++;
    total_cnt++; if (quarter_frame !== 1'b0) $display("FAIL inhibit_noimm got %b want 0", quarter_frame); else pass_cnt++;
    for (int e = 1; e <= 49; e++) begin
      cyc();
      total_cnt++; if (frame_irq !== 1'b0) $display("FAIL inhibit_irq e=%0d got %b want 0", e, frame_irq); else pass_cnt++;
    end
    total_cnt++; if (half_frame !== 1'b1) $display("FAIL inhibit_s3_half got %b want 1", half_frame); else pass_cnt++;
    total_cnt++; if (step !== 3'd0) $display("FAIL inhibit_wrap got %0d want 0", step); else pass_cnt++;
    cfg_write(8'h00);
    repeat (48) cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    total_cnt++; if (frame_irq !== 1'b1) $display("FAIL set_vs_ack got %b want 1", frame_irq); else pass_cnt++;
    total_cnt++; if (quarter_frame !== 1'b1) $display("FAIL set_vs_ack_q got %b want 1", quarter_frame); else pass_cnt++;
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    total_cnt++; if (frame_irq !== 1'b0) $display("FAIL ack_clear got %b want 0", frame_irq); else pass_cnt++;
    $display("irq inhibit/ack sequence done");
  endtask

  // 5-step: completions leave S0..S4 at edges 13,25,37,49,61; S3 silent.
  task automatic test_five_step();
    int k;
    logic expT, expQ, expH;
    logic [2:0] expS;
    cfg_write(8'h80);
    total_cnt++; if (quarter_frame !== 1'b1) $display("FAIL imm_quarter got %b want 1", quarter_frame); else pass_cnt++;
    total_cnt++; if (half_frame !== 1'b1) $display("FAIL imm_half got %b want 1", half_frame); else pass_cnt++;
    total_cnt++; if (step !== 3'd0) $display("FAIL imm_step got %0d want 0", step); else pass_cnt++;
    expS = 3'd0;
    for (int e = 1; e <= 61; e++) begin
      cyc();
      expT = (e % 4 == 0);
      expQ = 1'b0; expH = 1'b0;
      if (e >= 13 && (e - 13) % 12 == 0) begin
        k = (e - 13) / 12;
        expQ = (k % 5 != 3);
        expH = (k % 5 == 1) || (k % 5 == 4);
        expS = 3'((k + 1) % 5);
      end
      total_cnt++; if (sample_tick !== expT) $display("FAIL five_tick e=%0d got %b want %b", e, sample_tick, expT); else pass_cnt++;
      total_cnt++; if (quarter_frame !== expQ) $display("FAIL five_quarter e=%0d got %b want %b", e, quarter_frame, expQ); else pass_cnt++;
      total_cnt++; if (half_frame !== expH) $display("FAIL five_half e=%0d got %b want %b", e, half_frame, expH); else pass_cnt++;
      total_cnt++; if (step !== expS) $display("FAIL five_step e=%0d got %0d want %0d", e, step, expS); else pass_cnt++;
      total_cnt++; if (frame_irq !== 1'b0) $display("FAIL five_irq e=%0d got %b want 0", e, frame_irq); else pass_cnt++;
    end
    $display("five-step frame complete, step=%0d", step);
  endtask

  // Pause after edge 6 (tick_cnt=1); everything afterwards shifts by 10 edges.
  task automatic test_pause();
    logic expT, expQ;
    cfg_write(8'h00);
    repeat (6) cyc();
    apu_en = 1'b0;
    for (int e = 7; e <= 16; e++) begin
      cyc();
      total_cnt++; if (sample_tick !== 1'b0) $display("FAIL pause_tick e=%0d got %b want 0", e, sample_tick); else pass_cnt++;
      total_cnt++; if (quarter_frame !== 1'b0) $display("FAIL pause_quarter e=%0d got %b want 0", e, quarter_frame); else pass_cnt++;
      total_cnt++; if (step !== 3'd0) $display("FAIL pause_step e=%0d got %0d want 0", e, step); else pass_cnt++;
    end
    apu_en = 1'b1;
    for (int e = 17; e <= 23; e++) begin
      cyc();
      expT = (e == 18) || (e == 22);
      expQ = (e == 23);
      total_cnt++; if (sample_tick !== expT) $display("FAIL resume_tick e=%0d got %b want %b", e, sample_tick, expT); else pass_cnt++;
      total_cnt++; if (quarter_frame !== expQ) $display("FAIL resume_quarter e=%0d got %b want %b", e, quarter_frame, expQ); else pass_cnt++;
    end
    total_cnt++; if (step !== 3'd1) $display("FAIL resume_step got %0d want 1", step); else pass_cnt++;
    $display("pause/resume done, step=%0d", step);
  endtask

  // Write lands on the edge of the S1 completion: no strobe, counters restart.
  // Third tick follows 12 clks later, its strobe one clk after that.
  task automatic test_back_to_back();
    logic expT, expQ;
    logic [2:0] expS;
    repeat (11) cyc();
    cfg_write(8'h00);
    total_cnt++; if (quarter_frame !== 1'b0) $display("FAIL collide_quarter got %b want 0", quarter_frame); else pass_cnt++;
    total_cnt++; if (half_frame !== 1'b0) $display("FAIL collide_half got %b want 0", half_frame); else pass_cnt++;
    total_cnt++; if (step !== 3'd0) $display("FAIL collide_step got %0d want 0", step); else pass_cnt++;
    for (int e = 1; e <= 13; e++) begin
      cyc();
      expT = (e % 4 == 0);
      expQ = (e == 13);
      expS = (e == 13) ? 3'd1 : 3'd0;
      total_cnt++; if (sample_tick !== expT) $display("FAIL collide_tick e=%0d got %b want %b", e, sample_tick, expT); else pass_cnt++;
      total_cnt++; if (quarter_frame !== expQ) $display("FAIL collide_next_q e=%0d got %b want %b", e, quarter_frame, expQ); else pass_cnt++;
      total_cnt++; if (step !== expS) $display("FAIL collide_next_s e=%0d got %0d want %0d", e, step, expS); else pass_cnt++;
    end
    $display("write/step collision done");
  endtask

  task automatic test_async_reset();
    repeat (36) cyc();
    total_cnt++; if (frame_irq !== 1'b1) $display("FAIL pre_reset_irq got %b want 1", frame_irq); else pass_cnt++;
    cfg_write(8'h80);
    total_cnt++; if (frame_irq !== 1'b1) $display("FAIL mode_write_keeps_irq got %b want 1", frame_irq); else pass_cnt++;
    repeat (14) cyc();
    total_cnt++; if (step !== 3'd1) $display("FAIL pre_reset_step got %0d want 1", step); else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++; if (frame_irq !== 1'b0) $display("FAIL async_irq got %b want 0", frame_irq); else pass_cnt++;
    total_cnt++; if (step !== 3'd0) $display("FAIL async_step got %0d want 0", step); else pass_cnt++;
    total_cnt++; if (sample_tick !== 1'b0) $display("FAIL async_tick got %b want 0", sample_tick); else pass_cnt++;
    total_cnt++; if (quarter_frame !== 1'b0) $display("FAIL async_quarter got %b want 0", quarter_frame); else pass_cnt++;
    total_cnt++; if (half_frame !== 1'b0) $display("FAIL async_half got %b want 0", half_frame); else pass_cnt++;
    $display("async reset asserted at %0t", $time);
    repeat (2) cyc();
    rst = 1'b0;
    for (int e = 1; e <= 49; e++) begin
      cyc();
      if (e == 3) begin
        total_cnt++; if (sample_tick !== 1'b0) $display("FAIL rel_tick3 got %b want 0", sample_tick); else pass_cnt++;
      end
      if (e == 4) begin
        total_cnt++; if (sample_tick !== 1'b1) $display("FAIL rel_tick4 got %b want 1", sample_tick); else pass_cnt++;
      end
      if (e == 37) begin
        total_cnt++; if (step !== 3'd3) $display("FAIL rel_step37 got %0d want 3", step); else pass_cnt++;
      end
      if (e == 49) begin
        total_cnt++; if (quarter_frame !== 1'b1) $display("FAIL rel_s3_quarter got %b want 1", quarter_frame); else pass_cnt++;
        total_cnt++; if (half_frame !== 1'b1) $display("FAIL rel_s3_half got %b want 1", half_frame); else pass_cnt++;
        total_cnt++; if (frame_irq !== 1'b1) $display("FAIL rel_irq got %b want 1", frame_irq); else pass_cnt++;
        total_cnt++; if (step !== 3'd0) $display("FAIL rel_wrap got %0d want 0", step); else pass_cnt++;
      end
    end
    $display("post-reset frame back in 4-step mode");
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq_inhibit();
    test_five_step();
    test_pause();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
